// File: rtl/stim_gen_pkg.sv
// rtl/stim_gen_pkg.sv - shared types, LFSR constants and helpers for stim_gen
package stim_gen_pkg;

  // Enum literals carry a prefix so they stay visible inside stim_gen,
  // whose WARMUP parameter would otherwise shadow them.
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam logic [63:0] LFSR_TAPS        = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LANE_SEED_STRIDE = 64'h9E37_79B9_7F4A_7C15;

  // An all-zero Galois state is a lock-up point, so it is remapped to 1.
  function automatic logic [63:0] lane_seed(input logic [63:0] base, input int unsigned idx);
    logic [63:0] s;
    s = base ^ (64'(idx) * LANE_SEED_STRIDE);
    return (s == 64'h0) ? 64'h1 : s;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stim_gen_if.sv
// rtl/stim_gen_if.sv - stimulus/check bundle between stim_gen and its consumers
// Optional load ports appear when STIM_GEN_LOAD_EN is defined.
interface stim_gen_if #(
  parameter int DATAWIDTH = 64,
  parameter int NUM_LANES = 5
);
  logic                           en;
  logic [NUM_LANES*DATAWIDTH-1:0] stim;
  logic                           stim_valid;
  logic                           check_valid;
  logic [31:0]                    vec_count;
`ifdef STIM_GEN_LOAD_EN
  logic                           ld;
  logic [NUM_LANES*DATAWIDTH-1:0] ld_data;
`endif

  modport master (
    input  en,
`ifdef STIM_GEN_LOAD_EN
    input  ld,
    input  ld_data,
`endif
    output stim,
    output stim_valid,
    output check_valid,
    output vec_count
  );

  modport slave (
    output en,
`ifdef STIM_GEN_LOAD_EN
    output ld,
    output ld_data,
`endif
    input  stim,
    input  stim_valid,
    input  check_valid,
    input  vec_count
  );

endinterface

// File: rtl/stim_lfsr.sv
// rtl/stim_lfsr.sv - one 64-bit Galois right-shift LFSR lane, reset to its seed
module stim_lfsr
  import stim_gen_pkg::*;
#(
  parameter logic [63:0] SEED      = 64'h1,
  parameter int          DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [DATAWIDTH-1:0] next_lo
);

  logic [63:0] state_q;
  logic [63:0] state_d;
  logic [63:0] stepped;

  always_comb begin
    stepped = lfsr_step(state_q);
    state_d = step ? stepped : state_q;
  end

  // The top registers the post-step value, so it sees the successor state.
  assign next_lo = stepped[DATAWIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/stim_gen.sv
// rtl/stim_gen.sv - multi-lane pseudo-random stimulus source with latency-aligned check_valid
// Define STIM_GEN_LOAD_EN to add the ld/ld_data directed-vector path.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int          DATAWIDTH = 64,
  parameter int          NUM_LANES = 5,
  parameter int          LATENCY   = 3,
  parameter int          WARMUP    = 2,
  parameter logic [63:0] SEED      = 64'h1
) (
  input  logic      clk,
  input  logic      rst,
  stim_gen_if.master bus
);

  localparam int W = NUM_LANES * DATAWIDTH;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   stim_q, stim_d;
  logic           stim_valid_q, stim_valid_d;
  logic [31:0]    vec_count_q, vec_count_d;
  logic [W-1:0]   lfsr_next;
  logic           step;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    stim_lfsr #(
      .SEED      (lane_seed(SEED, i)),
      .DATAWIDTH (DATAWIDTH)
    ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .step    (step),
      .next_lo (lfsr_next[i*DATAWIDTH +: DATAWIDTH])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    stim_valid_d = 1'b0;
    vec_count_d  = vec_count_q;
    step         = 1'b0;
    if (state_q == ST_WARMUP) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(WARMUP)) begin
        state_d = ST_RUN;
      end
    end
`ifdef STIM_GEN_LOAD_EN
    // Directed vectors take priority and leave the LFSRs untouched.
    else if (bus.ld) begin
      stim_d       = bus.ld_data;
      stim_valid_d = 1'b1;
      vec_count_d  = sat_inc(vec_count_q);
    end
`endif
    else if (bus.en) begin
      step         = 1'b1;
      stim_d       = lfsr_next;
      stim_valid_d = 1'b1;
      vec_count_d  = sat_inc(vec_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WARMUP;
      cnt_q        <= 8'd0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      vec_count_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      vec_count_q  <= vec_count_d;
    end
  end

  // Delay line runs every cycle so paused tails still drain to the checker.
  if (LATENCY == 0) begin : g_lat0
    assign bus.check_valid = stim_valid_q;
  end else begin : g_lat
    logic [LATENCY-1:0] lat_q, lat_d;

    always_comb begin
      lat_d    = lat_q << 1;
      lat_d[0] = stim_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lat_q <= '0;
      end else begin
        lat_q <= lat_d;
      end
    end

    assign bus.check_valid = lat_q[LATENCY-1];
  end

  assign bus.stim       = stim_q;
  assign bus.stim_valid = stim_valid_q;
  assign bus.vec_count  = vec_count_q;

endmodule

// File: tb/tb_stim_gen.sv
// tb/tb_stim_gen.sv - scoreboard bench for stim_gen (default 64x5 and 8x2 builds)
module tb_stim_gen;

  localparam int DW  = 64;
  localparam int NL  = 5;
  localparam int LAT = 3;
  localparam int WU  = 2;
  localparam int SDW = 8;
  localparam int SNL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stim_gen_if #(.DATAWIDTH(DW),  .NUM_LANES(NL))  bus ();
  stim_gen_if #(.DATAWIDTH(SDW), .NUM_LANES(SNL)) sbus ();

  stim_gen #(
    .DATAWIDTH (DW), .NUM_LANES (NL), .LATENCY (LAT), .WARMUP (WU), .SEED (64'h1)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  stim_gen #(
    .DATAWIDTH (SDW), .NUM_LANES (SNL), .LATENCY (0), .WARMUP (WU), .SEED (64'h1)
  ) sdut (
    .clk (clk), .rst (rst), .bus (sbus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [63:0]          m_lane [NL];
  logic [63:0]          s_lane [SNL];
  bit                   m_run;
  int                   m_cnt;
  logic [31:0]          m_vc, s_vc;
  logic [NL*DW-1:0]     exp_q [$];
  logic [31:0]          expc_q [$];
  logic [SNL*SDW-1:0]   sexp_q [$];
  logic [31:0]          sexpc_q [$];
  logic [NL*DW-1:0]     m_last;
  logic [SNL*SDW-1:0]   s_last;
  bit                   pv_hist [$];
  logic [NL*DW-1:0]     ld_val;

  function automatic logic [63:0] gstep(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [63:0] seed_of(input int i);
    logic [63:0] s;
    s = 64'h1 ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    return (s == 64'h0) ? 64'h1 : s;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_cnt = 0;
    for (int l = 0; l < NL; l++) m_lane[l] = seed_of(l);
    for (int l = 0; l < SNL; l++) s_lane[l] = seed_of(l);
    m_vc = 0;
    s_vc = 0;
    m_last = '0;
    s_last = '0;
    exp_q.delete();
    expc_q.delete();
    sexp_q.delete();
    sexpc_q.delete();
    pv_hist.delete();
  endtask

  task automatic cyc(input bit en_m, input bit en_s, input bit ld_m);
    bit pv, spv;
    logic [NL*DW-1:0]   v, e;
    logic [SNL*SDW-1:0] sv, se;
    logic [31:0]        c;
    bit                 cv_exp;
    bus.en  = en_m;
    sbus.en = en_s;
`ifdef STIM_GEN_LOAD_EN
    bus.ld      = ld_m;
    bus.ld_data = ld_val;
    sbus.ld     = 1'b0;
    sbus.ld_data = '0;
`endif
    pv  = 0;
    spv = 0;
    if (!m_run) begin
      m_cnt++;
      if (m_cnt == WU) m_run = 1;
    end else begin
`ifdef STIM_GEN_LOAD_EN
      if (ld_m) begin
        exp_q.push_back(ld_val);
        pv = 1;
      end else
`endif
      if (en_m) begin
        for (int l = 0; l < NL; l++) begin
          m_lane[l] = gstep(m_lane[l]);
          v[l*DW +: DW] = m_lane[l][DW-1:0];
        end
        exp_q.push_back(v);
        pv = 1;
      end
      if (pv) begin
        m_vc = sat(m_vc);
        expc_q.push_back(m_vc);
      end
      if (en_s) begin
        for (int l = 0; l < SNL; l++) begin
          s_lane[l] = gstep(s_lane[l]);
          sv[l*SDW +: SDW] = s_lane[l][SDW-1:0];
        end
        sexp_q.push_back(sv);
        s_vc = sat(s_vc);
        sexpc_q.push_back(s_vc);
        spv = 1;
      end
    end
    pv_hist.push_back(pv);
    @(posedge clk);
    #1;
    check("stim_valid", 64'(bus.stim_valid), 64'(pv));
    if (bus.stim_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = expc_q.pop_front();
      m_last = e;
      for (int l = 0; l < NL; l++)
        check($sformatf("stim_lane%0d", l), bus.stim[l*DW +: DW], e[l*DW +: DW]);
      check("vec_count", 64'(bus.vec_count), 64'(c));
    end else begin
      for (int l = 0; l < NL; l++)
        check($sformatf("hold_lane%0d", l), bus.stim[l*DW +: DW], m_last[l*DW +: DW]);
      check("hold_vec_count", 64'(bus.vec_count), 64'(m_vc));
    end
    cv_exp = (pv_hist.size() > LAT) ? pv_hist[pv_hist.size()-1-LAT] : 1'b0;
    check("check_valid", 64'(bus.check_valid), 64'(cv_exp));
    check("s_stim_valid", 64'(sbus.stim_valid), 64'(spv));
    check("s_check_valid", 64'(sbus.check_valid), 64'(spv));
    if (sbus.stim_valid && sexp_q.size() > 0) begin
      se = sexp_q.pop_front();
      c  = sexpc_q.pop_front();
      s_last = se;
      check("s_stim", 64'(sbus.stim), 64'(se));
      check("s_vec_count", 64'(sbus.vec_count), 64'(c));
    end else begin
      check("s_hold", 64'(sbus.stim), 64'(s_last));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) check($sformatf("rst_lane%0d", l), bus.stim[l*DW +: DW], 64'h0);
    check("rst_stim_valid", 64'(bus.stim_valid), 64'h0);
    check("rst_check_valid", 64'(bus.check_valid), 64'h0);
    check("rst_vec_count", 64'(bus.vec_count), 64'h0);
    check("rst_s_stim", 64'(sbus.stim), 64'h0);
    check("rst_s_vec_count", 64'(sbus.vec_count), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_check_valid", 64'(bus.check_valid), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.en  = 1'b0;
    sbus.en = 1'b0;
    ld_val  = '1;
`ifdef STIM_GEN_LOAD_EN
    bus.ld  = 1'b0;
    bus.ld_data = '0;
    sbus.ld = 1'b0;
    sbus.ld_data = '0;
`endif
    model_reset();
    #2;
    do_reset();

    // warm-up ignores en, then first two vectors from seed 1
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("first_lane0", bus.stim[63:0], 64'hD800_0000_0000_0000);
    check("first_count", 64'(bus.vec_count), 64'd1);
    cyc(1, 0, 0);
    check("second_lane0", bus.stim[63:0], 64'h6C00_0000_0000_0000);
    check("second_count", 64'(bus.vec_count), 64'd2);

    // pause pattern and drain of the latency tail
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    check("ten_vectors", 64'(bus.vec_count), 64'd10);

    // asynchronous mid-cycle reset with vectors still in flight
    #3;
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("restart_lane0", bus.stim[63:0], 64'hD800_0000_0000_0000);

    for (int k = 0; k < 10; k++) cyc(k[0], 0, 0);
    for (int k = 0; k < 30; k++) cyc(1'($urandom_range(0, 1)), 0, 0);

    // saturation of the vector counter
    force dut.vec_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.vec_count_q;
    m_vc = 32'hFFFF_FFFE;
    repeat (3) cyc(1, 0, 0);
    check("vec_count_sat", 64'(bus.vec_count), 64'h0000_0000_FFFF_FFFF);

`ifdef STIM_GEN_LOAD_EN
    cyc(1, 0, 1);
    check("ld_stim", bus.stim[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("ld_valid", 64'(bus.stim_valid), 64'h1);
    repeat (3) cyc(1, 0, 0);
`endif

    // narrow two-lane build over a long run
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("s_first_lane0", 64'(sbus.stim[7:0]), 64'h00);
    check("s_lanes_differ", 64'(sbus.stim[15:8] != sbus.stim[7:0]), 64'h1);
    repeat (999) cyc(0, 1, 0);
    check("s_count_1000", 64'(sbus.vec_count), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stim_gen.md
Name: stim_gen

Overview:
- Synthesizable pseudo-random stimulus source for circuit benches.
- Drives the DUT and the behavioural model with identical vectors. Drives the comparator's qualifying valid, aligned to DUT latency.
- Producer end of the stimulus→check interface consumed by error_monitor.
- Replaces ad-hoc per-bench $random stimulus and warm-up counters.

Parameters:
- DATAWIDTH, 64, lane width in bits; legal range 1..64.
- NUM_LANES, 5, number of independent stimulus lanes.
- LATENCY, 3, cycles from stim_valid to check_valid; legal range 0..15.
- WARMUP, 2, cycles after reset release before generation starts; legal range 1..255.
- SEED, 64'h1, base LFSR seed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  advance request; one vector per cycle while high in RUN.
- stim  out  NUM_LANES*DATAWIDTH  lane i occupies bits [i*DATAWIDTH +: DATAWIDTH]; registered.
- stim_valid  out  1  stim updated this cycle.
- check_valid  out  1  stim_valid delayed LATENCY cycles; feeds error_monitor valid.
- vec_count  out  32  vectors issued; saturating.

Behaviour:
- Reset (async, any time, including mid-run):
  - stim=0, stim_valid=0, check_valid=0, vec_count=0.
  - Latency shift register cleared; state=WARMUP; warm-up counter=0.
  - Every lane LFSR reloads its seed.
- Lane seed i = SEED ^ (i * 64'h9E3779B97F4A7C15), truncated to 64 bits. A zero result is replaced by 64'h1, so lane 0 seed = SEED.
- LFSR: 64-bit Galois, right-shift: next = (s>>1) ^ (s[0] ? 64'hD800000000000000 : 0).
  - Always 64 bits wide internally.
  - stim lane = low DATAWIDTH bits of the state.
- FSM:
  - WARMUP:
    - Counts clk edges with rst low; en ignored; stim held 0; stim_valid 0.
    - Counter reaches WARMUP → RUN.
    - With WARMUP=2, the first RUN edge is the 3rd rising edge after rst falls.
  - RUN, en=1: every LFSR steps; stim <= low bits of the new state; stim_valid <= 1; vec_count += 1 (saturates at 32'hFFFFFFFF, no wrap).
    - First vector = step(seed), never the seed itself.
  - RUN, en=0: LFSRs and stim hold; stim_valid <= 0.
  - No exit from RUN except reset.
- check_valid:
  - Shift register of depth LATENCY fed by stim_valid; shifts every cycle regardless of en, so the in-flight tail drains after a pause.
  - LATENCY=0: check_valid is combinationally equal to stim_valid.
  - Result: check_valid pulse pattern equals stim_valid pattern delayed exactly LATENCY cycles, gaps included.
- en toggling every cycle is legal; each high cycle yields exactly one vector.

Optional Feature:
- Macro: STIM_GEN_LOAD_EN.
- Defined: adds ports ld (in, 1) and ld_data (in, NUM_LANES*DATAWIDTH). In RUN with ld=1:
  - stim <= ld_data; stim_valid <= 1; vec_count increments.
  - LFSRs do not step; ld has priority over en.
  - ld in WARMUP is ignored.
- Undefined: ports absent; behaviour as above. Purpose: directed corner vectors (0, all-ones, max-signed) interleaved with random.

Decomposition:
- Package stim_gen_pkg:
  - state enum {WARMUP, RUN}.
  - LFSR_TAPS = 64'hD800000000000000.
  - LANE_SEED_STRIDE = 64'h9E3779B97F4A7C15.
  - Function lane_seed(base, idx).
- One sub-module, stim_lfsr: a single 64-bit lane with seed parameter, step enable, async reset to seed. Instantiated NUM_LANES times in a generate loop.
- The latency shift register stays inline.

Test Plan:
- Warm-up/first vector: SEED=1, WARMUP=2, en=1 from reset release:
  - stim_valid=0 for the first 2 edges after rst falls.
  - 3rd edge: lane0=64'hD800000000000000; 4th edge: 64'h6C00000000000000; vec_count=1 then 2.
- Pause/latency: LATENCY=3, en pattern 1,1,0,0,1:
  - check_valid = 1,1,0,0,1 starting 3 cycles after the first stim_valid.
  - stim unchanged during en=0.
- Mid-run reset: assert rst asynchronously between edges after 10 vectors:
  - All outputs 0 immediately; check_valid tail discarded.
  - After re-warm-up, lane0 sequence restarts at 64'hD800000000000000.
- Width/lanes: DATAWIDTH=8, NUM_LANES=2, SEED=1:
  - lane0 first vector = 8'h00; lane1 differs from lane0.
  - Each lane equals the low byte of a software Galois model over 1000 steps.
- Saturation: force vec_count to 32'hFFFFFFFE, issue 3 vectors → 32'hFFFFFFFF, held.
- STIM_GEN_LOAD_EN: ld=1 with ld_data=all-ones while en=1:
  - stim=all-ones; stim_valid=1.
  - Next en-only cycle resumes the LFSR sequence with no step skipped.
